// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and imem.
// The fetch unit is the master: it drives the request and address; memory answers.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC owner and instruction fetcher for the single-cycle MIPS core: fetch over req/ack,
// hold IR for one execute cycle, then apply the Control_Unit's next-PC selection.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         funct,
  output logic               instr_valid,
  input  logic [1:0]         next_pc_sel,
  input  logic [31:0]        rs_data,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  input  logic               halt,
  output logic               addr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic        addr_err_reg, addr_err_next;
  logic        req_reg, valid_reg;
  logic [31:0] branch_offset, jump_target, target;

  assign pc_plus4      = pc_reg + 32'(PC_STEP);
  assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], instr_reg[25:0], 2'b00};

  always_comb begin
    target = pc_plus4;
    case (next_pc_sel)
      2'b00:   target = pc_plus4;
      2'b01:   target = pc_plus4 + branch_offset;
      2'b10:   target = jump_target;
      default: target = rs_data;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    instr_next    = instr_reg;
    addr_err_next = addr_err_reg;
    case (state_reg)
      IDLE: begin
        if (!halt) state_next = FETCH;
      end
      FETCH: begin
        if (imem.imem_ack) begin
          instr_next = imem.imem_rdata;
          state_next = EXEC;
        end
      end
      EXEC: begin
        // A misaligned target freezes the core with the faulting PC still visible.
        if (target[1:0] != 2'b00) begin
          addr_err_next = 1'b1;
          state_next    = STOP;
        end else begin
          pc_next    = target;
          state_next = halt ? IDLE : FETCH;
        end
      end
      STOP: begin
        state_next = STOP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      pc_reg       <= RESET_PC;
      instr_reg    <= 32'h0;
      addr_err_reg <= 1'b0;
      req_reg      <= 1'b0;
      valid_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      instr_reg    <= instr_next;
      addr_err_reg <= addr_err_next;
      // Handshake outputs are registered from the upcoming state so they align with it.
      req_reg      <= (state_next == FETCH);
      valid_reg    <= (state_next == EXEC);
    end
  end

  assign imem.imem_req  = req_reg;
  assign imem.imem_addr = pc_reg;
  assign instr          = instr_reg;
  assign opcode         = instr_reg[31:26];
  assign funct          = instr_reg[5:0];
  assign instr_valid    = valid_reg;
  assign pc             = pc_reg;
  assign addr_err       = addr_err_reg;

endmodule
